// File: rtl/csi_pkg.sv
// Shared CSI-2 packet constants, the receive-side state type and the 6-bit header ECC function.
package csi_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_LS    = 6'h02;
    localparam logic [5:0] DT_LE    = 6'h03;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    // Data types below this value are short packets.
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [1:0] {
        StHdr,
        StPayload,
        StSkip
    } csi_state_e;

    // Each ECC bit is the parity of a fixed subset of the 24 header bits.
    function automatic logic [5:0] csi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

endpackage

// File: rtl/csi_ecc_check.sv
// Combinational check of a received packet header against its 6-bit ECC field.
module csi_ecc_check
    import csi_pkg::*;
(
    input  logic [23:0] hdr_i,
    input  logic [5:0]  ecc_i,
    output logic        ecc_ok_o
);

    assign ecc_ok_o = (csi_ecc(hdr_i) == ecc_i);

endmodule

// File: rtl/csi_packet_parser.sv
// CSI-2 packet parser: decodes word-aligned headers, emits sync pulses and forwards RAW10
// payload words with byte enables; every output is registered one cycle after its input word.
module csi_packet_parser
    import csi_pkg::*;
#(
    parameter logic [1:0]  VC       = 2'd0,
    parameter logic [5:0]  DT_RAW10 = 6'h2B,
    parameter int unsigned WC_W     = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [31:0]     byte_data_i,
    input  logic            byte_valid_i,
    input  logic            lp_i,
    output logic [31:0]     data_o,
    output logic            data_valid_o,
    output logic [3:0]      data_be_o,
    output logic            fsync_o,
    output logic            fend_o,
    output logic            lsync_o,
    output logic            line_end_o,
    output logic            ecc_err_o,
    output logic            trunc_err_o,
    output logic [WC_W-1:0] line_cnt_o
);

    localparam logic [WC_W:0]   REM_FOUR = (WC_W+1)'(4);
    localparam logic [WC_W:0]   REM_CRC  = (WC_W+1)'(2);
    localparam logic [WC_W-1:0] PAY_FOUR = WC_W'(4);

    csi_state_e      state_q;
    logic [WC_W:0]   rem_q;
    logic [WC_W-1:0] pay_q;
    logic            first_q;
    logic [31:0]     data_q;
    logic [3:0]      be_q;
    logic            data_valid_q;
    logic            fsync_q;
    logic            fend_q;
    logic            lsync_q;
    logic            line_end_q;
    logic            ecc_err_q;
    logic            trunc_err_q;
    logic [WC_W-1:0] line_cnt_q;

    logic            ecc_ok;
    logic [1:0]      hdr_vc;
    logic [5:0]      hdr_dt;
    logic [WC_W-1:0] hdr_wc;
    logic [2:0]      pay_n;
    logic [2:0]      rem_n;
    logic [3:0]      pay_be;

    csi_ecc_check u_ecc_check (
        .hdr_i    (byte_data_i[23:0]),
        .ecc_i    (byte_data_i[29:24]),
        .ecc_ok_o (ecc_ok)
    );

    assign hdr_vc = byte_data_i[7:6];
    assign hdr_dt = byte_data_i[5:0];
    assign hdr_wc = WC_W'(byte_data_i[23:8]);

    always_comb begin
        pay_n = (pay_q >= PAY_FOUR) ? 3'd4 : pay_q[2:0];
        rem_n = (rem_q >= REM_FOUR) ? 3'd4 : rem_q[2:0];
        case (pay_n)
            3'd0:    pay_be = 4'b0000;
            3'd1:    pay_be = 4'b0001;
            3'd2:    pay_be = 4'b0011;
            3'd3:    pay_be = 4'b0111;
            default: pay_be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StHdr;
            rem_q        <= '0;
            pay_q        <= '0;
            first_q      <= 1'b0;
            data_q       <= '0;
            be_q         <= '0;
            data_valid_q <= 1'b0;
            fsync_q      <= 1'b0;
            fend_q       <= 1'b0;
            lsync_q      <= 1'b0;
            line_end_q   <= 1'b0;
            ecc_err_q    <= 1'b0;
            trunc_err_q  <= 1'b0;
            line_cnt_q   <= '0;
        end else begin
            // Valid and pulse outputs last one cycle; data, enables and counters hold.
            data_valid_q <= 1'b0;
            fsync_q      <= 1'b0;
            fend_q       <= 1'b0;
            lsync_q      <= 1'b0;
            line_end_q   <= 1'b0;
            ecc_err_q    <= 1'b0;
            trunc_err_q  <= 1'b0;

            if (lp_i && state_q != StHdr) begin
                trunc_err_q <= 1'b1;
                state_q     <= StHdr;
            end else if (byte_valid_i) begin
                unique case (state_q)
                    StHdr: begin
                        if (!ecc_ok) begin
                            ecc_err_q <= 1'b1;
                        end else if (hdr_dt < DT_LONG_MIN) begin
                            if (hdr_vc == VC) begin
                                case (hdr_dt)
                                    DT_FS: begin
                                        fsync_q    <= 1'b1;
                                        line_cnt_q <= '0;
                                    end
                                    DT_FE:   fend_q  <= 1'b1;
                                    DT_LS:   lsync_q <= 1'b1;
                                    default: ;
                                endcase
                            end
                        end else begin
                            rem_q   <= {1'b0, hdr_wc} + REM_CRC;
                            pay_q   <= hdr_wc;
                            first_q <= 1'b1;
                            state_q <= (hdr_vc == VC && hdr_dt == DT_RAW10) ? StPayload : StSkip;
                        end
                    end
                    StPayload: begin
                        if (pay_n != 3'd0) begin
                            data_q       <= byte_data_i;
                            be_q         <= pay_be;
                            data_valid_q <= 1'b1;
                            lsync_q      <= first_q;
                            first_q      <= 1'b0;
                            if (pay_q <= PAY_FOUR) begin
                                line_end_q <= 1'b1;
                                if (line_cnt_q != '1) begin
                                    line_cnt_q <= line_cnt_q + 1'b1;
                                end
                            end
                        end
                        pay_q <= pay_q - WC_W'(pay_n);
                        rem_q <= rem_q - (WC_W+1)'(rem_n);
                        if (rem_q <= REM_FOUR) begin
                            state_q <= StHdr;
                        end
                    end
                    StSkip: begin
                        rem_q <= rem_q - (WC_W+1)'(rem_n);
                        if (rem_q <= REM_FOUR) begin
                            state_q <= StHdr;
                        end
                    end
                    default: state_q <= StHdr;
                endcase
            end
        end
    end

    assign data_o       = data_q;
    assign data_be_o    = be_q;
    assign data_valid_o = data_valid_q;
    assign fsync_o      = fsync_q;
    assign fend_o       = fend_q;
    assign lsync_o      = lsync_q;
    assign line_end_o   = line_end_q;
    assign ecc_err_o    = ecc_err_q;
    assign trunc_err_o  = trunc_err_q;
    assign line_cnt_o   = line_cnt_q;

endmodule

// File: tb/tb_csi_packet_parser.sv
// Scoreboard bench for csi_packet_parser: each driven word queues its expected registered outputs.
module tb_csi_packet_parser;
    import csi_pkg::*;

    typedef struct packed {
        logic        dv;
        logic [3:0]  be;
        logic [31:0] data;
        logic [5:0]  fl;   // {fsync, fend, lsync, line_end, ecc_err, trunc_err}
        logic [15:0] cnt;
    } out_t;

    localparam logic [5:0] F_FS = 6'b100000;
    localparam logic [5:0] F_FE = 6'b010000;
    localparam logic [5:0] F_LS = 6'b001000;
    localparam logic [5:0] F_LE = 6'b000100;
    localparam logic [5:0] F_EE = 6'b000010;
    localparam logic [5:0] F_TE = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] byte_data_i = '0;
    logic        byte_valid_i = 1'b0;
    logic        lp_i = 1'b0;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic [3:0]  data_be_o;
    logic        fsync_o, fend_o, lsync_o, line_end_o, ecc_err_o, trunc_err_o;
    logic [15:0] line_cnt_o;

    int checks = 0;
    int fails = 0;
    int n_pushed = 0;
    int n_sampled = 0;
    out_t exp_q[$];
    out_t obs_q[$];

    always #5 clk = ~clk;

    csi_packet_parser #(
        .VC       (2'd0),
        .DT_RAW10 (6'h2B),
        .WC_W     (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .byte_data_i  (byte_data_i),
        .byte_valid_i (byte_valid_i),
        .lp_i         (lp_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_be_o    (data_be_o),
        .fsync_o      (fsync_o),
        .fend_o       (fend_o),
        .lsync_o      (lsync_o),
        .line_end_o   (line_end_o),
        .ecc_err_o    (ecc_err_o),
        .trunc_err_o  (trunc_err_o),
        .line_cnt_o   (line_cnt_o)
    );

    // Data and enables are only meaningful with data_valid_o, so the masked view zeroes them.
    function automatic out_t sample(input bit mask);
        out_t r;
        r.dv   = data_valid_o;
        r.be   = (mask && !data_valid_o) ? 4'h0 : data_be_o;
        r.data = (mask && !data_valid_o) ? 32'h0 : data_o;
        r.fl   = {fsync_o, fend_o, lsync_o, line_end_o, ecc_err_o, trunc_err_o};
        r.cnt  = line_cnt_o;
        return r;
    endfunction

    function automatic out_t mk(input logic [3:0] be, input logic [31:0] d, input logic [5:0] fl,
                                input logic [15:0] cnt);
        out_t r;
        r.dv   = |be;
        r.be   = be;
        r.data = (|be) ? d : 32'h0;
        r.fl   = fl;
        r.cnt  = cnt;
        return r;
    endfunction

    function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                        input logic [15:0] wc);
        logic [23:0] h;
        h = {wc, vc, dt};
        return {2'b00, csi_ecc(h), h};
    endfunction

    function automatic logic [31:0] bad_hdr(input logic [23:0] h);
        return {2'b00, csi_ecc(h) ^ 6'h2A, h};
    endfunction

    always @(posedge clk) begin
        if (n_sampled < n_pushed) begin
            #1;
            obs_q.push_back(sample(1'b1));
            n_sampled++;
        end
    end

    task automatic cyc(input logic [31:0] d, input logic v, input logic lp, input out_t e);
        @(negedge clk);
        byte_data_i  = d;
        byte_valid_i = v;
        lp_i         = lp;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
            lp_i         = 1'b0;
        end
    endtask

    task automatic test_reset();
        out_t o;
        #3;
        o = sample(1'b0);
        checks++;
        if (o !== '0) begin
            fails++;
            $display("FAIL reset_hold: got %h want %h", o, out_t'('0));
        end
        @(negedge clk);
        rst_ni = 1'b1;
        idle(2);
        o = sample(1'b0);
        checks++;
        if (o !== '0) begin
            fails++;
            $display("FAIL reset_release: got %h want %h", o, out_t'('0));
        end
    endtask

    task automatic test_short_packets();
        out_t e, o;
        cyc(hdr(2'd0, DT_FS, 16'h0000), 1'b1, 1'b0, mk(4'h0, 0, F_FS, 16'd0));
        cyc(32'hFFFF_FFFF, 1'b0, 1'b0, mk(4'h0, 0, 6'b0, 16'd0));
        cyc(hdr(2'd1, DT_LS, 16'h0000), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd0));
        cyc(hdr(2'd0, DT_LE, 16'h0000), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd0));
        cyc(hdr(2'd0, 6'h08, 16'h1234), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd0));
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL short_packets: no output, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL short_packets: got %h want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_raw10_line();
        out_t e, o;
        cyc(hdr(2'd0, 6'h2B, 16'd10), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd0));
        cyc(32'h1122_3344, 1'b1, 1'b0, mk(4'hF, 32'h1122_3344, F_LS, 16'd0));
        cyc(32'h5566_7788, 1'b1, 1'b0, mk(4'hF, 32'h5566_7788, 6'b0, 16'd0));
        cyc(32'hCAFE_99AA, 1'b1, 1'b0, mk(4'h3, 32'hCAFE_99AA, F_LE, 16'd1));
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL raw10_line: no output, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL raw10_line: got %h want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_ecc_error();
        out_t e, o;
        cyc(hdr(2'd0, 6'h2B, 16'd10) ^ 32'h0100_0000, 1'b1, 1'b0, mk(4'h0, 0, F_EE, 16'd1));
        cyc(bad_hdr(24'h112233), 1'b1, 1'b0, mk(4'h0, 0, F_EE, 16'd1));
        cyc(bad_hdr(24'h4455AB), 1'b1, 1'b0, mk(4'h0, 0, F_EE, 16'd1));
        cyc(bad_hdr(24'h000000), 1'b1, 1'b0, mk(4'h0, 0, F_EE, 16'd1));
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL ecc_error: no output, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL ecc_error: got %h want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_skip_long();
        out_t e, o;
        cyc(hdr(2'd0, 6'h12, 16'd6), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(hdr(2'd0, DT_FS, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(32'hDEAD_BEEF, 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(hdr(2'd0, DT_FE, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, F_FE, 16'd1));
        cyc(hdr(2'd1, 6'h2B, 16'd4), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(32'h0102_0304, 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(32'h0506_0708, 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(hdr(2'd0, 6'h2B, 16'd0), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(hdr(2'd0, DT_LS, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(hdr(2'd0, DT_LS, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, F_LS, 16'd1));
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL skip_long: no output, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL skip_long: got %h want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_truncate();
        out_t e, o;
        cyc(hdr(2'd0, 6'h2B, 16'd20), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(32'hA1A2_A3A4, 1'b1, 1'b0, mk(4'hF, 32'hA1A2_A3A4, F_LS, 16'd1));
        cyc(32'hB1B2_B3B4, 1'b1, 1'b0, mk(4'hF, 32'hB1B2_B3B4, 6'b0, 16'd1));
        cyc(32'hC1C2_C3C4, 1'b1, 1'b1, mk(4'h0, 0, F_TE, 16'd1));
        cyc(hdr(2'd0, DT_FS, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, F_FS, 16'd0));
        cyc(hdr(2'd0, DT_FS, 16'h0), 1'b0, 1'b1, mk(4'h0, 0, 6'b0, 16'd0));
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL truncate: no output, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL truncate: got %h want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        cyc(hdr(2'd0, 6'h2B, 16'd5), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd0));
        cyc(32'h1357_9BDF, 1'b1, 1'b0, mk(4'hF, 32'h1357_9BDF, F_LS, 16'd0));
        cyc(32'hFFFF_FFFF, 1'b0, 1'b0, mk(4'h0, 0, 6'b0, 16'd0));
        cyc(32'h2468_ACE0, 1'b1, 1'b0, mk(4'h1, 32'h2468_ACE0, F_LE, 16'd1));
        cyc(hdr(2'd0, DT_LS, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, F_LS, 16'd1));
        cyc(hdr(2'd0, 6'h2B, 16'd4), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd1));
        cyc(32'h0F0F_F0F0, 1'b1, 1'b0, mk(4'hF, 32'h0F0F_F0F0, F_LS | F_LE, 16'd2));
        cyc(hdr(2'd0, DT_FS, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd2));
        cyc(hdr(2'd0, DT_FE, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, F_FE, 16'd2));
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL back_to_back: no output, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL back_to_back: got %h want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        out_t e, o;
        cyc(hdr(2'd0, 6'h2B, 16'd20), 1'b1, 1'b0, mk(4'h0, 0, 6'b0, 16'd2));
        cyc(32'h7777_8888, 1'b1, 1'b0, mk(4'hF, 32'h7777_8888, F_LS, 16'd2));
        @(negedge clk);
        byte_data_i  = 32'h9999_AAAA;
        byte_valid_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        o = sample(1'b0);
        checks++;
        if (o !== '0) begin
            fails++;
            $display("FAIL reset_mid_async: got %h want %h", o, out_t'('0));
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        cyc(hdr(2'd0, DT_FS, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, F_FS, 16'd0));
        cyc(hdr(2'd0, DT_LS, 16'h0), 1'b1, 1'b0, mk(4'h0, 0, F_LS, 16'd0));
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL reset_mid: no output, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL reset_mid: got %h want %h", o, e);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_short_packets();
        test_raw10_line();
        test_ecc_error();
        test_skip_long();
        test_truncate();
        test_back_to_back();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/csi_packet_parser.md
Name: csi_packet_parser

Overview:
- Sits directly upstream of the RAW10 unpacker in the MIPI CSI-2 receive path.
- Consumes the 32-bit lane-merged byte stream from the D-PHY lane aligner, one word per valid cycle, byte 0 in [7:0]. The aligner places each packet header word-aligned.
- Decodes CSI-2 packet headers and checks the header ECC.
- Emits frame/line sync pulses and forwards RAW10 long-packet payload words with byte enables to the unpacker.

Parameters:
- VC, 2'd0, virtual channel to accept; packets on any other VC are consumed and discarded.
- DT_RAW10, 6'h2B, long-packet data type whose payload is forwarded.
- WC_W, 16, word-count width.

Ports:
- clk_i  in  1  block clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- byte_data_i  in  32  aligned byte stream, byte0 = [7:0].
- byte_valid_i  in  1  byte_data_i valid this cycle.
- lp_i  in  1  lane returned to LP (end of HS burst); aborts any open packet.
- data_o  out  32  payload word to the unpacker.
- data_valid_o  out  1  data_o valid.
- data_be_o  out  4  byte enables for data_o; bit n covers [8n+7:8n].
- fsync_o  out  1  one-cycle pulse on a Frame Start short packet.
- fend_o  out  1  one-cycle pulse on a Frame End short packet.
- lsync_o  out  1  one-cycle pulse on a Line Start short packet, or on the first payload word of a RAW10 packet.
- line_end_o  out  1  asserted with the last payload word of a RAW10 packet.
- ecc_err_o  out  1  one-cycle pulse when a header ECC mismatches.
- trunc_err_o  out  1  one-cycle pulse when lp_i aborts an open packet.
- line_cnt_o  out  WC_W  RAW10 lines since the last FS.

Behaviour:
- Reset: every output is 0; state = HDR; counters are 0.
- Outputs are registered; latency from the input word to the corresponding output is exactly 1 cycle.
- Header fields from the HDR word:
  - DI = byte0; VC = DI[7:6]; DT = DI[5:0].
  - WC = {byte2, byte1}.
  - ECC = byte3[5:0].
- ECC check:
  - Compute the CSI-2 6-bit Hamming ECC over bits [23:0]; compare with byte3[5:0].
  - Detection only; no correction.
- States:
  - HDR: wait for a valid word.
    - ECC mismatch: ecc_err_o pulses; stay in HDR; nothing else is emitted.
    - DT < 0x10 (short packet): decode and stay in HDR.
      - DT 0x00 pulses fsync_o and clears line_cnt_o.
      - DT 0x01 pulses fend_o.
      - DT 0x02 pulses lsync_o.
      - DT 0x03 and any other short DT produce no output.
      - A non-matching VC produces no output.
    - DT >= 0x10 (long packet): load rem = WC + 2 (payload plus CRC) and pay = WC.
      - VC match and DT == DT_RAW10: go to PAYLOAD.
      - Otherwise: go to SKIP.
  - PAYLOAD, on each valid word:
    - n = min(4, pay); data_be_o = low n bits set; data_valid_o = 1 when n > 0.
    - Decrement pay by n and rem by min(4, rem).
    - lsync_o pulses with the first forwarded word.
    - line_end_o pulses with the word where pay reaches 0; line_cnt_o increments at the same time.
    - When rem <= 4 before the decrement, return to HDR. Trailing bytes in that word are ignored.
  - SKIP: same rem accounting as PAYLOAD; nothing is output.
- WC = 0 long packet: no data word, no lsync_o, no line_end_o; the CRC word is consumed; return to HDR.
- CRC bytes are consumed but not checked.
- lp_i = 1 has priority over byte_valid_i:
  - In PAYLOAD or SKIP: trunc_err_o pulses and state goes to HDR; line_end_o is not asserted.
  - In HDR: no effect.
- byte_valid_i = 0 stalls: state, counters and outputs hold, except that valid and pulse outputs drop to 0.
- line_cnt_o saturates at all ones.
- Reset mid-packet returns to HDR immediately. The unpacker sees data_valid_o = 0.

Decomposition:
- Package csi_pkg:
  - DT constants: DT_FS = 6'h00, DT_FE = 6'h01, DT_LS = 6'h02, DT_LE = 6'h03, DT_RAW10 = 6'h2B.
  - Function csi_ecc(input [23:0]) returning [5:0].
  - State enum HDR/PAYLOAD/SKIP.
- One sub-module, csi_ecc_check: combinational; ECC compute plus compare; output ecc_ok. The bench reuses csi_pkg::csi_ecc as its model.

Test Plan:
- Word {ecc, 00, 00, 00}, VC0 FS, correct ECC -> fsync_o = 1 for one cycle, 1 cycle later; line_cnt_o = 0.
- RAW10 header DI = 0x2B, WC = 10, then 3 payload words -> data_valid_o on 3 cycles; data_be_o = 4'hF, 4'hF, 4'h3; lsync_o on word 1; line_end_o on word 3; line_cnt_o = 1.
- Same header with ECC bit 0 flipped -> ecc_err_o pulse; the following 3 words are treated as headers; no data_valid_o for the RAW10 payload.
- Long packet DT = 0x12, WC = 6, then 2 words, then FE -> no data_valid_o; fend_o pulses on the FE word; state is HDR afterwards.
- RAW10 WC = 20; lp_i asserted after 2 payload words -> 2 data words (be 4'hF); trunc_err_o pulse; no line_end_o; next FS decoded normally.
- rst_ni low during the second payload word -> all outputs 0 asynchronously; after release, an FS header -> fsync_o pulse.
